// File: rtl/rfs_pio_pkg.sv
// Shared constants for the rfs PIO input block: register map, edge modes, counter width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rfs_pio_pkg;

    // Avalon word addresses
    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd1;
    localparam logic [1:0] ADDR_EDGE  = 2'd2;
    localparam logic [1:0] ADDR_COUNT = 2'd3;

    // EDGE_MODE encodings
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Edge-event counter
    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/rfs_sync_vec.sv
// Multi-flop synchroniser for a vector of asynchronous inputs.
// Latency: STAGES clocks from i_din to o_dout.
// Backpressure: none, samples every clock.
//
// Ports: clk, reset_n (async active-low), i_din (async inputs), o_dout (synchronised).
module rfs_sync_vec #(
    parameter int WIDTH  = 12,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [STAGES-1:0][WIDTH-1:0] r_ff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ff <= '0;
        end else begin
            r_ff <= {r_ff[STAGES-2:0], i_din};
        end
    end

    assign o_dout = r_ff[STAGES-1];

endmodule

// File: rtl/rfs_pio_in_edge.sv
// Avalon-MM input PIO with synchroniser, per-bit edge capture (W1C), IRQ mask and event counter.
// Latency: read data 1 clock after address; in_port to edge_cap/irq SYNC_STAGES+1 clocks.
// Backpressure: none, slave always accepts (no waitrequest).
//
// Ports: clk, reset_n (async active-low); Avalon address/chipselect/write_n/writedata/readdata;
//        in_port (async status inputs); irq (registered level interrupt).
module rfs_pio_in_edge #(
    parameter int WIDTH       = 12,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    import rfs_pio_pkg::*;

    // Arming waits for the synchroniser and sync_prev to fill with real samples.
    localparam int ARM_CYCLES = SYNC_STAGES + 1;
    localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] r_sync_prev;
    logic [WIDTH-1:0] r_edge_cap;
    logic [WIDTH-1:0] r_mask;
    logic [CNT_W-1:0] r_evt_cnt;
    logic [ARM_W-1:0] r_arm_cnt;
    logic [31:0]      r_readdata;
    logic             r_irq;

    logic             w_armed;
    logic             w_wr;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge_sel;
    logic [WIDTH-1:0] w_edge;
    logic             w_any_edge;
    logic [WIDTH-1:0] w_w1c;
    logic [WIDTH-1:0] w_edge_cap_next;
    logic [WIDTH-1:0] w_mask_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [31:0]      w_rdata;
    logic             w_unused_wdata;

    rfs_sync_vec #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_din   (in_port),
        .o_dout  (w_sync)
    );

    assign w_armed = (r_arm_cnt == ARM_W'(ARM_CYCLES));
    assign w_wr    = chipselect & ~write_n;

    assign w_rise = w_sync & ~r_sync_prev;
    assign w_fall = ~w_sync & r_sync_prev;

    always_comb begin
        w_edge_sel = w_rise | w_fall;
        case (EDGE_MODE)
            EDGE_RISE: w_edge_sel = w_rise;
            EDGE_FALL: w_edge_sel = w_fall;
            default:   w_edge_sel = w_rise | w_fall;
        endcase
    end

    assign w_edge     = w_armed ? w_edge_sel : '0;
    assign w_any_edge = |w_edge;

    // New edges OR in after the clear, so a same-cycle edge survives its W1C.
    assign w_w1c           = (w_wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    assign w_edge_cap_next = (r_edge_cap & ~w_w1c) | w_edge;
    assign w_mask_next     = (w_wr && address == ADDR_MASK) ? writedata[WIDTH-1:0] : r_mask;

    // Counter clear restarts at 1 when an edge lands in the same cycle.
    always_comb begin
        w_cnt_next = r_evt_cnt;
        if (w_wr && address == ADDR_COUNT) begin
            w_cnt_next = w_any_edge ? CNT_W'(1) : '0;
        end else if (w_any_edge && r_evt_cnt != CNT_MAX) begin
            w_cnt_next = r_evt_cnt + CNT_W'(1);
        end
    end

    // Read mux uses current register state, i.e. before any same-cycle write.
    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_DATA:  w_rdata[WIDTH-1:0] = w_sync;
            ADDR_MASK:  w_rdata[WIDTH-1:0] = r_mask;
            ADDR_EDGE:  w_rdata[WIDTH-1:0] = r_edge_cap;
            ADDR_COUNT: w_rdata[CNT_W-1:0] = r_evt_cnt;
            default:    w_rdata = '0;
        endcase
    end

    // Upper writedata bits are unused when WIDTH < 32.
    assign w_unused_wdata = &{1'b0, writedata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_arm_cnt   <= '0;
            r_sync_prev <= '0;
            r_edge_cap  <= '0;
            r_mask      <= '0;
            r_evt_cnt   <= '0;
            r_readdata  <= '0;
            r_irq       <= 1'b0;
        end else begin
            if (!w_armed) begin
                r_arm_cnt <= r_arm_cnt + ARM_W'(1);
            end
            r_sync_prev <= w_sync;
            r_edge_cap  <= w_edge_cap_next;
            r_mask      <= w_mask_next;
            r_evt_cnt   <= w_cnt_next;
            r_readdata  <= w_rdata;
            r_irq       <= |(w_edge_cap_next & w_mask_next);
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule

// File: tb/tb_rfs_pio_in_edge.sv
// Directed self-checking bench for rfs_pio_in_edge: three instances share one Avalon bus
// (rise/12-bit, any/12-bit, fall/32-bit) with independent in_port drives.
// Latency checked: read data 1 clock, irq within SYNC_STAGES+2 clocks of an input edge.
module tb_rfs_pio_in_edge;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;

    logic [11:0] in0 = 12'hFFF;
    logic [11:0] in2 = 12'h000;
    logic [31:0] in32 = 32'hA5A5_0001;
    logic [31:0] rd0, rd2, rd32;
    logic        irq0, irq2, irq32;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    rfs_pio_in_edge #(.WIDTH(12), .SYNC_STAGES(2), .EDGE_MODE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0));

    rfs_pio_in_edge #(.WIDTH(12), .SYNC_STAGES(2), .EDGE_MODE(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in2), .readdata(rd2), .irq(irq2));

    rfs_pio_in_edge #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_MODE(1)) dut32 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in32), .readdata(rd32), .irq(irq32));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a;
        tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;

        // Reset held with all-ones input on dut0
        #2;
        chk("rst_rd0", rd0, 32'h0);
        chk("rst_irq0", {31'd0, irq0}, 32'h0);
        ticks(3);
        reset_n = 1'b1;
        ticks(10);
        bus_read(2'd0);
        chk("arm_data0", rd0, 32'h0000_0FFF);
        bus_read(2'd2);
        chk("arm_edge0", rd0, 32'h0);
        bus_read(2'd3);
        chk("arm_count0", rd0, 32'h0);
        chk("arm_irq0", {31'd0, irq0}, 32'h0);

        // 32-bit instance: DATA, read-only DATA, MASK width, read latency, falling edge
        bus_read(2'd0);
        chk("w32_data", rd32, 32'hA5A5_0001);
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_read(2'd0);
        chk("w32_data_ro", rd32, 32'hA5A5_0001);
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd1);
        chk("w32_mask", rd32, 32'hFFFF_FFFF);
        chk("w12_mask_upper0", rd0, 32'h0000_0FFF);
        address = 2'd0;
        #2;
        chk("lat_hold", rd32, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        chk("lat_one", rd32, 32'hA5A5_0001);
        in32 = 32'hA5A5_0000;
        ticks(5);
        bus_read(2'd2);
        chk("w32_fall_edge", rd32, 32'h0000_0001);
        chk("w32_irq", {31'd0, irq32}, 32'h1);

        // Rising mode: falling edge ignored, rising edge captured, W1C drops irq
        bus_write(2'd1, 32'h0000_0001);
        in0 = 12'hFFE;
        ticks(5);
        chk("rise_ignore_fall", {31'd0, irq0}, 32'h0);
        in0 = 12'hFFF;
        n = 0;
        while (irq0 !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("rise_irq_lat_ok", {31'd0, (n <= 4)}, 32'h1);
        bus_read(2'd2);
        chk("rise_edge", rd0, 32'h0000_0001);
        bus_read(2'd3);
        chk("rise_count", rd0, 32'h0000_0001);
        bus_write(2'd2, 32'h0000_0001);
        chk("w1c_irq_drop", {31'd0, irq0}, 32'h0);

        // Set wins over same-cycle W1C on bit 3
        in0 = 12'hFF7;
        ticks(5);
        in0 = 12'hFFF;
        ticks(2);
        bus_write(2'd2, 32'h0000_0008);
        bus_read(2'd2);
        chk("set_wins_edge", rd0, 32'h0000_0008);
        bus_read(2'd3);
        chk("set_wins_count", rd0, 32'h0000_0002);
        chk("set_wins_irq_masked", {31'd0, irq0}, 32'h0);

        // Any-edge mode: bits 0 and 5 pulsed together three times -> 6 edge cycles
        for (int k = 0; k < 3; k++) begin
            in2 = 12'h021;
            ticks(5);
            in2 = 12'h000;
            ticks(5);
        end
        bus_read(2'd3);
        chk("any_count6", rd2, 32'h0000_0006);
        bus_read(2'd2);
        chk("any_edge", rd2, 32'h0000_0021);
        chk("any_irq", {31'd0, irq2}, 32'h1);

        // Saturation, clear, and clear/edge collision
        for (int k = 0; k < 70000; k++) begin
            in2[0] = ~in2[0];
            tick();
        end
        ticks(5);
        bus_read(2'd3);
        chk("cnt_saturate", rd2, 32'h0000_FFFF);
        bus_write(2'd3, 32'h0);
        bus_read(2'd3);
        chk("cnt_clear", rd2, 32'h0);
        in2[0] = ~in2[0];
        ticks(2);
        bus_write(2'd3, 32'h0);
        bus_read(2'd3);
        chk("cnt_clear_collide", rd2, 32'h0000_0001);

        // Pending edge hidden by mask, exposed by mask write
        bus_write(2'd1, 32'h0);
        bus_write(2'd2, 32'h0000_0FFF);
        in0 = 12'hFEF;
        ticks(5);
        in0 = 12'hFFF;
        ticks(5);
        bus_read(2'd2);
        chk("pend_edge", rd0, 32'h0000_0010);
        chk("pend_irq_masked", {31'd0, irq0}, 32'h0);
        bus_write(2'd1, 32'h0000_0010);
        chk("mask_expose_irq", {31'd0, irq0}, 32'h1);

        // Asynchronous reset mid-operation
        address = 2'd2;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_irq0", {31'd0, irq0}, 32'h0);
        chk("arst_rd0", rd0, 32'h0);
        ticks(2);
        reset_n = 1'b1;
        bus_read(2'd1);
        chk("arst_mask0", rd0, 32'h0);
        bus_read(2'd2);
        chk("arst_edge0", rd0, 32'h0);
        bus_read(2'd3);
        chk("arst_count2", rd2, 32'h0);
        ticks(6);
        chk("rearm_irq0", {31'd0, irq0}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rfs_pio_in_edge.md
Name: rfs_pio_in_edge

Overview:
- Parametrised Avalon-MM slave input PIO for HPS/Nios status capture (e.g. image height, sensor flags), WIDTH bits wide.
- Adds features a plain read-only PIO lacks:
  - a SYNC_STAGES-deep input synchroniser;
  - per-bit edge capture with write-1-to-clear;
  - an interrupt mask and level IRQ;
  - a 16-bit saturating edge-event counter.
- Sits between fabric status signals and the lightweight HPS-to-FPGA bridge.

Parameters:
- WIDTH, 12, input port width; legal range 1..32.
- SYNC_STAGES, 2, synchroniser flops on in_port; legal range 2..4.
- EDGE_MODE, 0, edge type captured: 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0
- writedata  in  32  write data
- in_port  in  WIDTH  asynchronous status inputs
- readdata  out  32  registered read data
- irq  out  1  registered level interrupt

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock clk. All of the following reset to 0:
  - synchroniser flops, sync_prev, edge_cap, mask, evt_cnt;
  - readdata = 0, irq = 0;
  - arm counter cleared.
- Synchroniser and arming:
  - in_port passes through SYNC_STAGES flops to give sync; sync_prev = sync delayed one cycle.
  - Edge detection is disarmed until SYNC_STAGES+1 rising clocks after reset release. A high input at reset therefore never produces a false edge.
- Edge detect, per bit i, only when armed:
  - rise = sync & ~sync_prev;
  - fall = ~sync & sync_prev;
  - edge selected by EDGE_MODE.
- Register map (read and write):
  - Address 0, DATA (RO): zero-extended sync. Writes are ignored.
  - Address 1, MASK (RW): bits [WIDTH-1:0] are writable; upper bits read 0.
  - Address 2, EDGE (W1C): edge_cap. Writing 1 to bit i clears it.
  - Address 3, COUNT (RO value, any write clears): evt_cnt in bits [15:0].
- Edge/clear collision: if a new edge on bit i occurs in the same cycle as a W1C on bit i, the bit ends set (set wins).
- evt_cnt:
  - increments by 1 in any cycle where at least one bit edges (per cycle, not per bit);
  - saturates at 0xFFFF.
  - If a write to address 3 coincides with an edge, the result is 1.
- Reads:
  - readdata updates every clock from the address mux, independent of chipselect. Read latency is 1 cycle.
  - A read reflects state before any same-cycle write.
- irq: registered; irq <= |(edge_cap_next & mask_next). It asserts the cycle after the capture, or after a mask write that exposes a pending bit.
- Register width: all internal registers are WIDTH bits except evt_cnt (16 bits). No X propagation when WIDTH=32.
- Reset mid-operation: asynchronously clears everything, including pending irq. Re-arming restarts from zero.

Decomposition:
- Shared package rfs_pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_MASK=1, ADDR_EDGE=2, ADDR_COUNT=3;
  - EDGE_RISE/EDGE_FALL/EDGE_ANY encodings;
  - CNT_W=16.
- One sub-module, rfs_sync_vec: parametrised WIDTH × SYNC_STAGES synchroniser with async reset.
- Edge logic, registers and read mux remain in the top module.

Test Plan:
- Reset with in_port=12'hFFF held, release, wait 10 cycles -> DATA reads 0xFFF; EDGE=0, COUNT=0, irq=0 (arming suppresses false edge).
- EDGE_MODE=0: MASK=0x001, then pulse in_port[0] 0->1 -> EDGE=0x001, COUNT=1, irq=1 within SYNC_STAGES+2 cycles. Write EDGE=0x001 -> irq=0 next cycle.
- Rising edge on bit 3 in the same cycle the bus writes EDGE=0x008 -> EDGE reads 0x008 afterwards (set wins).
- Toggle bits 0 and 5 together 3 times, EDGE_MODE=2 -> COUNT=6 (one per changing cycle). Force 70000 edge cycles -> COUNT=0xFFFF. Write address 3 -> COUNT=0.
- Pending EDGE=0x010 with MASK=0: irq=0. Write MASK=0x010 -> irq=1 next cycle. Assert reset_n=0 mid-sequence -> irq, readdata and all registers 0 asynchronously.
- WIDTH=32, in_port=32'hA5A5_0001 -> DATA reads 0xA5A5_0001. Writes to DATA leave it unchanged. Read data appears exactly one cycle after the address is presented.
